// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Byte-addressed, big-endian memory responder for the MFA/MFC handshake.
// One request is latched per MFA assertion. A byte, halfword or word read or
// write is performed LATENCY cycles later. MFC then stays high until the
// initiator withdraws MFA.
//
// Parameters:
//   ADDR_W  - byte address bits used (storage depth 2^ADDR_W bytes)
//   LATENCY - wait cycles from request capture to MFC (1..15)
//
// Ports:
//   Clk     in   1  clock, rising edge
//   Reset   in   1  asynchronous active-low reset
//   MFA     in   1  memory function activate (level)
//   RW      in   1  1 = read, 0 = write
//   SIZE    in   2  00 byte, 01 halfword, 1x word
//   SE      in   1  sign-extend byte/halfword reads
//   ADDR    in  32  byte address (bits above ADDR_W-1 ignored)
//   DataIn  in  32  write data, right-justified
//   DataOut out 32  read data, right-justified, valid while MFC=1
//   MFC     out  1  memory function complete
//   MAE     out  1  misaligned-address error
//
// Configuration macro:
//   MEM_ALIGN_CHECK_EN - when defined, a misaligned halfword or word request
//                        completes with MAE=1 and has no effect. When
//                        undefined, MAE is 0 and the low address bits are
//                        forced to zero.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic        SE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        MAE
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  // Backing store. It has no reset, so contents survive Reset.
  logic [7:0] ram [0:DEPTH-1];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              se_q, se_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic [31:0]       dout_q, dout_d;
  logic              mfc_q, mfc_d;
  logic              mae_q, mae_d;

  logic [ADDR_W-1:0] addr_cap_s;
  logic              mis_cap_s;
  logic [ADDR_W-1:0] a0_s, a1_s, a2_s, a3_s;
  logic [31:0]       rdata_s;
  logic              last_s;
  logic              wr_en_s;
  logic              unused_addr_s;

  // Clear the low address bits so that the access is naturally aligned.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0] sz);
    logic [ADDR_W-1:0] r;
    case (sz)
      2'b00:   r = a;
      2'b01:   r = {a[ADDR_W-1:1], 1'b0};
      default: r = {a[ADDR_W-1:2], 2'b00};
    endcase
    return r;
  endfunction

  // Report whether a request breaks natural alignment for its size.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] a,
                                         input logic [1:0] sz);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = a[0];
      default: r = (a[1:0] != 2'b00);
    endcase
    return r;
  endfunction

  // Address bits above ADDR_W-1 are deliberately ignored.
  assign unused_addr_s = ^ADDR[31:ADDR_W];

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_cap_s = ADDR[ADDR_W-1:0];
  assign mis_cap_s  = is_misaligned(ADDR[ADDR_W-1:0], SIZE);
`else
  assign addr_cap_s = align_addr(ADDR[ADDR_W-1:0], SIZE);
  assign mis_cap_s  = 1'b0;
`endif

  // Big-endian lane addresses. Each lane address wraps modulo 2^ADDR_W.
  assign a0_s = addr_q;
  assign a1_s = addr_q + ADDR_W'(1);
  assign a2_s = addr_q + ADDR_W'(2);
  assign a3_s = addr_q + ADDR_W'(3);

  // Right-justify the read data. Sign-extend narrow reads when SE is set.
  always_comb begin
    rdata_s = 32'h0;
    case (size_q)
      2'b00:   rdata_s = {{24{se_q & ram[a0_s][7]}}, ram[a0_s]};
      2'b01:   rdata_s = {{16{se_q & ram[a0_s][7]}}, ram[a0_s], ram[a1_s]};
      default: rdata_s = {ram[a0_s], ram[a1_s], ram[a2_s], ram[a3_s]};
    endcase
  end

  assign last_s  = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign wr_en_s = last_s && !rw_q && !mis_q;

  // Next-state logic for the handshake FSM and the request registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    se_d    = se_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    mae_d   = mae_q;
    case (state_q)
      ST_IDLE: begin
        if (MFA) begin
          rw_d    = RW;
          size_d  = SIZE;
          se_d    = SE;
          addr_d  = addr_cap_s;
          wdata_d = DataIn;
          mis_d   = mis_cap_s;
          cnt_d   = LAT_M1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          mfc_d   = 1'b1;
          mae_d   = mis_q;
          // A misaligned read leaves DataOut untouched.
          if (rw_q && !mis_q) begin
            dout_d = rdata_s;
          end else begin
            dout_d = dout_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // A new request cannot be captured here. MFA must be seen low first.
        if (!MFA) begin
          state_d = ST_IDLE;
          mfc_d   = 1'b0;
          mae_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mfc_d   = 1'b0;
        mae_d   = 1'b0;
      end
    endcase
  end

  // Control and request registers with asynchronous reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      se_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
      dout_q  <= 32'h0;
      mfc_q   <= 1'b0;
      mae_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      se_q    <= se_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      mae_q   <= mae_d;
    end
  end

  // Byte-lane writes on the final BUSY edge. Only the selected bytes change.
  always_ff @(posedge Clk) begin
    if (wr_en_s) begin
      case (size_q)
        2'b00: begin
          ram[a0_s] <= wdata_q[7:0];
        end
        2'b01: begin
          ram[a0_s] <= wdata_q[15:8];
          ram[a1_s] <= wdata_q[7:0];
        end
        default: begin
          ram[a0_s] <= wdata_q[31:24];
          ram[a1_s] <= wdata_q[23:16];
          ram[a2_s] <= wdata_q[15:8];
          ram[a3_s] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;
  assign MAE     = mae_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MFA;
  logic        RW;
  logic [1:0]  SIZE;
  logic        SE;
  logic [31:0] ADDR;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;
  logic        MAE;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder #(.ADDR_W(9), .LATENCY(2)) dut (
    .Clk(Clk), .Reset(Reset), .MFA(MFA), .RW(RW), .SIZE(SIZE), .SE(SE),
    .ADDR(ADDR), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .MAE(MAE)
  );

  always #5 Clk = ~Clk;

  // Present a request on a falling edge. MFA is sampled on the next rising edge.
  task automatic drive_req(input logic rw, input logic [1:0] sz, input logic se,
                           input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    RW = rw; SIZE = sz; SE = se; ADDR = a; DataIn = d; MFA = 1'b1;
  endtask

  // Run a full handshake. Report the cycles until MFC, the data and MAE seen
  // in DONE, and MFC one edge after MFA is dropped.
  task automatic run_req(input logic rw, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d,
                         output int cyc, output logic [31:0] dout,
                         output logic mae, output logic mfc_after);
    drive_req(rw, sz, se, a, d);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      cyc++;
      if (MFC === 1'b1) break;
    end
    dout = DataOut;
    mae  = MAE;
    MFA  = 1'b0;
    @(negedge Clk);
    mfc_after = MFC;
  endtask

  task automatic test_reset();
    int cyc; logic [31:0] d; logic m, fa;
    n_tests++;
    if (MFC !== 1'b0 || DataOut !== 32'h0 || MAE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: MFC=%b DataOut=%h MAE=%b, required 0/00000000/0", MFC, DataOut, MAE);
    end
    run_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h11223344) begin
      n_fail++; $display("FAIL reset_preread: got %h, required 11223344", d);
    end
    // Start a write, then reset while it is still in BUSY.
    drive_req(1'b0, 2'b10, 1'b0, 32'd8, 32'hA5A5A5A5);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    n_tests++;
    if (MFC !== 1'b0 || DataOut !== 32'h0 || MAE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: MFC=%b DataOut=%h MAE=%b, required 0/00000000/0", MFC, DataOut, MAE);
    end
    @(negedge Clk);
    MFA = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    run_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (cyc !== 3 || d !== 32'h11223344 || fa !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_read: cyc=%0d data=%h mfc_after=%b, required 3/11223344/0", cyc, d, fa);
    end
  endtask

  task automatic test_word_read_latency();
    int cyc;
    drive_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h0);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      cyc++;
      if (MFC === 1'b1) break;
    end
    n_tests++;
    if (cyc !== 3) begin
      n_fail++; $display("FAIL latency: MFC after %0d edges, required 3", cyc);
    end
    n_tests++;
    if (DataOut !== 32'h9C044012 || MAE !== 1'b0) begin
      n_fail++; $display("FAIL word_read: got %h MAE=%b, required 9c044012 MAE=0", DataOut, MAE);
    end
    // MFC holds while MFA stays high, and nothing new is captured.
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      n_tests++;
      if (MFC !== 1'b1 || DataOut !== 32'h9C044012) begin
        n_fail++; $display("FAIL mfc_hold: MFC=%b DataOut=%h, required 1/9c044012", MFC, DataOut);
      end
    end
    MFA = 1'b0;
    @(negedge Clk);
    n_tests++;
    if (MFC !== 1'b0) begin
      n_fail++; $display("FAIL mfc_drop: MFC=%b, required 0", MFC);
    end
    @(negedge Clk);
    n_tests++;
    if (MFC !== 1'b0) begin
      n_fail++; $display("FAIL mfc_idle: MFC=%b, required 0", MFC);
    end
  endtask

  task automatic test_byte_half();
    int cyc; logic [31:0] d; logic m, fa;
    run_req(1'b0, 2'b00, 1'b0, 32'd5, 32'hFFFFFFAB, cyc, d, m, fa);
    n_tests++;
    if (cyc !== 3 || d !== 32'h9C044012 || fa !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_write: cyc=%0d DataOut=%h mfc_after=%b, required 3/9c044012/0", cyc, d, fa);
    end
    run_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h9CAB4012) begin
      n_fail++; $display("FAIL word_after_byte: got %h, required 9cab4012", d);
    end
    run_req(1'b1, 2'b01, 1'b1, 32'd4, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'hFFFF9CAB) begin
      n_fail++; $display("FAIL half_se1: got %h, required ffff9cab", d);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'd4, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h00009CAB) begin
      n_fail++; $display("FAIL half_se0: got %h, required 00009cab", d);
    end
    run_req(1'b1, 2'b00, 1'b1, 32'd4, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'hFFFFFF9C) begin
      n_fail++; $display("FAIL byte_se1_neg: got %h, required ffffff9c", d);
    end
    run_req(1'b1, 2'b00, 1'b1, 32'd7, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h00000012) begin
      n_fail++; $display("FAIL byte_se1_pos: got %h, required 00000012", d);
    end
    run_req(1'b0, 2'b01, 1'b0, 32'd6, 32'h1234ABCD, cyc, d, m, fa);
    run_req(1'b1, 2'b10, 1'b1, 32'd4, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h9CABABCD) begin
      n_fail++; $display("FAIL half_write_word_se: got %h, required 9cababcd", d);
    end
  endtask

  task automatic test_early_drop();
    logic [4:0] seq;
    drive_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h0);
    @(negedge Clk);
    seq[0] = MFC;
    MFA = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(negedge Clk);
      seq[i] = MFC;
      if (i == 2) begin
        n_tests++;
        if (DataOut !== 32'h11223344) begin
          n_fail++; $display("FAIL early_drop_data: got %h, required 11223344", DataOut);
        end
      end
    end
    // The edges after capture are k+1 .. k+4. MFC is high only after k+2.
    n_tests++;
    if (seq !== 5'b00100) begin
      n_fail++; $display("FAIL early_drop_mfc: MFC sequence %b, required 00100", seq);
    end
  endtask

  task automatic test_misaligned();
    int cyc; logic [31:0] d; logic m, fa;
`ifdef MEM_ALIGN_CHECK_EN
    run_req(1'b1, 2'b10, 1'b0, 32'd6, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (cyc !== 3 || m !== 1'b1 || d !== 32'h11223344 || fa !== 1'b0 || MAE !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_read: cyc=%0d MAE=%b data=%h mfc_after=%b mae_after=%b, required 3/1/11223344/0/0",
               cyc, m, d, fa, MAE);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'd5, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (m !== 1'b1 || d !== 32'h11223344) begin
      n_fail++; $display("FAIL mis_half: MAE=%b data=%h, required 1/11223344", m, d);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'd6, 32'hDEADBEEF, cyc, d, m, fa);
    n_tests++;
    if (m !== 1'b1) begin
      n_fail++; $display("FAIL mis_write_mae: MAE=%b, required 1", m);
    end
    run_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h9CABABCD || m !== 1'b0) begin
      n_fail++; $display("FAIL mis_write_nochange: got %h MAE=%b, required 9cababcd/0", d, m);
    end
`else
    run_req(1'b1, 2'b10, 1'b0, 32'd6, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h9CABABCD || m !== 1'b0) begin
      n_fail++; $display("FAIL align_read: got %h MAE=%b, required 9cababcd/0", d, m);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'd6, 32'hDEADBEEF, cyc, d, m, fa);
    run_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL align_write: got %h, required deadbeef", d);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'd5, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h0000DEAD || m !== 1'b0) begin
      n_fail++; $display("FAIL align_half: got %h MAE=%b, required 0000dead/0", d, m);
    end
`endif
  endtask

  task automatic test_wrap();
    int cyc; logic [31:0] d; logic m, fa;
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFEF00D, cyc, d, m, fa);
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL wrap_word: got %h, required cafef00d", d);
    end
    run_req(1'b1, 2'b00, 1'b0, 32'hFFFF_FE03, 32'h0, cyc, d, m, fa);
    n_tests++;
    if (d !== 32'h0000000D) begin
      n_fail++; $display("FAIL wrap_byte: got %h, required 0000000d", d);
    end
  endtask

  initial begin
    Reset = 1'b0; MFA = 1'b0; RW = 1'b0; SIZE = 2'b00; SE = 1'b0;
    ADDR = 32'h0; DataIn = 32'h0;
    dut.ram[4]  = 8'h9C; dut.ram[5]  = 8'h04; dut.ram[6]  = 8'h40; dut.ram[7]  = 8'h12;
    dut.ram[8]  = 8'h11; dut.ram[9]  = 8'h22; dut.ram[10] = 8'h33; dut.ram[11] = 8'h44;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    test_reset();
    test_word_read_latency();
    test_byte_half();
    test_early_drop();
    test_misaligned();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
